// File: rtl/branch_predictor_bht.sv
// Branch direction unit: 2-bit saturating counter table with RISC-V branch resolve.
// Define ARVI_BHT_STATS_EN to add saturating branch/mispredict statistics outputs.
module branch_predictor_bht #(
  parameter int         ENTRIES  = 64,
  parameter int         PC_WIDTH = 32,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_lookup_valid,
  input  logic [PC_WIDTH-1:0] i_lookup_pc,
  output logic                o_pred_valid,
  output logic                o_pred_taken,
  input  logic                i_res_valid,
  input  logic [PC_WIDTH-1:0] i_res_pc,
  input  logic [2:0]          i_res_f3,
  input  logic                i_res_Z,
  input  logic                i_res_Res,
  input  logic                i_res_pred_taken,
  output logic                o_res_valid,
  output logic                o_res_taken,
  output logic                o_mispredict,
  output logic                o_invalid_f3
`ifdef ARVI_BHT_STATS_EN
  ,
  output logic [31:0]         o_stat_branches,
  output logic [31:0]         o_stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  logic [1:0]       cnt_q [ENTRIES];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] res_idx;
  logic             f3_legal;
  logic             actual_taken;
  logic             train_en;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_upd;
  logic [1:0]       lk_cnt;

  logic pred_valid_q, pred_valid_d;
  logic pred_taken_q, pred_taken_d;
  logic res_valid_q, res_valid_d;
  logic res_taken_q, res_taken_d;
  logic mispredict_q, mispredict_d;
  logic invalid_f3_q, invalid_f3_d;

  // Only the index bits of either PC select a counter; the rest is untagged.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_lookup_pc, i_res_pc};

  assign lk_idx  = i_lookup_pc[IDX_W+1:2];
  assign res_idx = i_res_pc[IDX_W+1:2];

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    f3_legal     = 1'b1;
    actual_taken = 1'b0;
    case (branch_f3_e'(i_res_f3))
      F3_BEQ:           actual_taken = i_res_Z;
      F3_BNE:           actual_taken = ~i_res_Z;
      F3_BLT, F3_BLTU:  actual_taken = i_res_Res;
      F3_BGE, F3_BGEU:  actual_taken = ~i_res_Res;
      default:          f3_legal     = 1'b0;
    endcase
  end

  assign train_en = i_res_valid & f3_legal;
  assign cnt_cur  = cnt_q[res_idx];

  always_comb begin
    cnt_upd = cnt_cur;
    if (actual_taken && cnt_cur != 2'b11) begin
      cnt_upd = cnt_cur + 2'd1;
    end else if (!actual_taken && cnt_cur != 2'b00) begin
      cnt_upd = cnt_cur - 2'd1;
    end
  end

  // A same-cycle resolve to the looked-up index forwards its updated counter.
  assign lk_cnt = (train_en && (lk_idx == res_idx)) ? cnt_upd : cnt_q[lk_idx];

  always_comb begin
    pred_valid_d = i_lookup_valid;
    pred_taken_d = i_lookup_valid ? lk_cnt[1] : pred_taken_q;
    res_valid_d  = i_res_valid;
    res_taken_d  = train_en & actual_taken;
    mispredict_d = train_en & (actual_taken != i_res_pred_taken);
    invalid_f3_d = i_res_valid & ~f3_legal;
  end

  // NOTE: the table is built from flops, not a RAM macro, so it can and must be reset to INIT_CNT.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= INIT_CNT;
      end
    end else if (train_en) begin
      cnt_q[res_idx] <= cnt_upd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      invalid_f3_q <= 1'b0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      mispredict_q <= mispredict_d;
      invalid_f3_q <= invalid_f3_d;
    end
  end

  assign o_pred_valid = pred_valid_q;
  assign o_pred_taken = pred_taken_q;
  assign o_res_valid  = res_valid_q;
  assign o_res_taken  = res_taken_q;
  assign o_mispredict = mispredict_q;
  assign o_invalid_f3 = invalid_f3_q;

`ifdef ARVI_BHT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (train_en && stat_br_q != 32'hFFFF_FFFF) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (mispredict_d && stat_mis_q != 32'hFFFF_FFFF) begin
      stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stat_br_q  <= 32'd0;
      stat_mis_q <= 32'd0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign o_stat_branches    = stat_br_q;
  assign o_stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed vector table, reset
// sequences, and a randomised phase scored against a behavioural counter model.
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        res_valid_i;
  logic [31:0] res_pc;
  logic [2:0]  res_f3;
  logic        res_z;
  logic        res_lt;
  logic        res_pred;
  logic        res_valid_o;
  logic        res_taken;
  logic        mispredict;
  logic        invalid_f3;
`ifdef ARVI_BHT_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor_bht #(
    .ENTRIES (64),
    .PC_WIDTH(32),
    .INIT_CNT(2'b01)
  ) dut (
    .i_clk           (clk),
    .i_rstn          (rst_n),
    .i_lookup_valid  (lookup_valid),
    .i_lookup_pc     (lookup_pc),
    .o_pred_valid    (pred_valid),
    .o_pred_taken    (pred_taken),
    .i_res_valid     (res_valid_i),
    .i_res_pc        (res_pc),
    .i_res_f3        (res_f3),
    .i_res_Z         (res_z),
    .i_res_Res       (res_lt),
    .i_res_pred_taken(res_pred),
    .o_res_valid     (res_valid_o),
    .o_res_taken     (res_taken),
    .o_mispredict    (mispredict),
    .o_invalid_f3    (invalid_f3)
`ifdef ARVI_BHT_STATS_EN
    ,
    .o_stat_branches   (stat_branches),
    .o_stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lk_v;
    logic [31:0] lk_pc;
    logic        rs_v;
    logic [31:0] rs_pc;
    logic [2:0]  f3;
    logic        z;
    logic        lt;
    logic        pred;
    logic        e_pv, e_pt, e_rv, e_rt, e_mis, e_inv;
  } vec_t;

  typedef struct {
    logic pv, pt, rv, rt, mis, inv;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural reference for the randomised phase.
  bit [1:0] m_cnt[64];
  bit       m_pt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  task automatic v(input logic lk_v, input logic [31:0] lk_pc, input logic rs_v,
                   input logic [31:0] rs_pc, input logic [2:0] f3, input logic z,
                   input logic lt, input logic pred, input logic e_pv, input logic e_pt,
                   input logic e_rv, input logic e_rt, input logic e_mis, input logic e_inv);
    vec_t t;
    t.lk_v = lk_v;  t.lk_pc = lk_pc; t.rs_v = rs_v; t.rs_pc = rs_pc;
    t.f3 = f3;      t.z = z;         t.lt = lt;     t.pred = pred;
    t.e_pv = e_pv;  t.e_pt = e_pt;   t.e_rv = e_rv; t.e_rt = e_rt;
    t.e_mis = e_mis; t.e_inv = e_inv;
    vecs.push_back(t);
  endtask

  task automatic check_outs(input string tag, input exp_t g);
    check({tag, ".pred_valid"}, 32'(pred_valid), 32'(g.pv));
    check({tag, ".pred_taken"}, 32'(pred_taken), 32'(g.pt));
    check({tag, ".res_valid"},  32'(res_valid_o), 32'(g.rv));
    check({tag, ".res_taken"},  32'(res_taken), 32'(g.rt));
    check({tag, ".mispredict"}, 32'(mispredict), 32'(g.mis));
    check({tag, ".invalid_f3"}, 32'(invalid_f3), 32'(g.inv));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic apply(input vec_t t, input string tag);
    exp_t e;
    exp_t g;
    lookup_valid = t.lk_v; lookup_pc = t.lk_pc;
    res_valid_i  = t.rs_v; res_pc    = t.rs_pc;
    res_f3 = t.f3; res_z = t.z; res_lt = t.lt; res_pred = t.pred;
    e.pv = t.e_pv; e.pt = t.e_pt; e.rv = t.e_rv;
    e.rt = t.e_rt; e.mis = t.e_mis; e.inv = t.e_inv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check_outs(tag, g);
  endtask

  task automatic run_vecs(input string pfx);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("%s%0d", pfx, i));
    end
    vecs.delete();
  endtask

  task automatic idle_inputs();
    lookup_valid = 1'b0; lookup_pc = '0;
    res_valid_i  = 1'b0; res_pc    = '0;
    res_f3 = 3'b0; res_z = 1'b0; res_lt = 1'b0; res_pred = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) m_cnt[i] = 2'b01;
    m_pt = 1'b0;
  endtask

  // Expected outputs for one random cycle, derived from the branch rules directly.
  task automatic model_step(inout vec_t t);
    bit legal, act, tr;
    legal = t.f3[2] | ~t.f3[1];
    act   = (t.f3[2] ? t.lt : t.z) ^ t.f3[0];
    tr    = t.rs_v & legal;
    if (tr) begin
      if (act) m_cnt[t.rs_pc[7:2]] = (m_cnt[t.rs_pc[7:2]] == 2'd3) ? 2'd3 : m_cnt[t.rs_pc[7:2]] + 2'd1;
      else     m_cnt[t.rs_pc[7:2]] = (m_cnt[t.rs_pc[7:2]] == 2'd0) ? 2'd0 : m_cnt[t.rs_pc[7:2]] - 2'd1;
    end
    if (t.lk_v) m_pt = m_cnt[t.lk_pc[7:2]][1];
    t.e_pv = t.lk_v; t.e_pt = m_pt; t.e_rv = t.rs_v;
    t.e_rt = tr & act; t.e_mis = tr & (act != t.pred); t.e_inv = t.rs_v & ~legal;
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    exp_t zero_e;
    zero_e = '{default: 1'b0};
    rst_n = 1'b0;
    idle_inputs();
    do_reset();
    #1;
    check_outs("reset", zero_e);

    // Directed table: training, saturation, bypass, aliasing, illegal f3.
    v(1, 'h100, 0, 0,     3'd0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    v(0, 0,     1, 'h100, 3'd0, 1, 0, 0,  0, 0, 1, 1, 1, 0);
    v(0, 0,     1, 'h100, 3'd0, 1, 0, 0,  0, 0, 1, 1, 1, 0);
    v(1, 'h100, 0, 0,     3'd0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    v(0, 0,     0, 0,     3'd0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      v(0, 0,   1, 'h40,  3'd0, 1, 0, 1,  0, 1, 1, 1, 0, 0);
    v(0, 0,     1, 'h40,  3'd1, 1, 0, 1,  0, 1, 1, 0, 1, 0);
    v(1, 'h40,  0, 0,     3'd0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    v(1, 'h80,  1, 'h80,  3'd4, 0, 1, 0,  1, 1, 1, 1, 1, 0);
    v(1, 'h104, 0, 0,     3'd0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    v(0, 0,     1, 'h004, 3'd6, 0, 1, 0,  0, 0, 1, 1, 1, 0);
    v(1, 'h104, 0, 0,     3'd0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    v(0, 0,     1, 'h104, 3'd2, 1, 1, 1,  0, 1, 1, 0, 0, 1);
    v(0, 0,     1, 'h104, 3'd3, 1, 1, 1,  0, 1, 1, 0, 0, 1);
    v(1, 'h104, 0, 0,     3'd0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    v(0, 0,     1, 'h104, 3'd5, 0, 1, 1,  0, 1, 1, 0, 1, 0);
    v(1, 'h104, 0, 0,     3'd0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    v(0, 0,     1, 'h80,  3'd7, 0, 0, 1,  0, 0, 1, 1, 0, 0);
    v(0, 0,     1, 'h80,  3'd0, 0, 0, 1,  0, 0, 1, 0, 1, 0);
    v(1, 'h80,  1, 'h80,  3'd1, 1, 0, 1,  1, 0, 1, 0, 1, 0);
    v(0, 0,     0, 'h80,  3'd0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    v(1, 'h80,  0, 0,     3'd0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    run_vecs("dir");

    // Mid-operation reset: outputs clear asynchronously and the table reinitialises.
    v(1, 'h100, 1, 'h100, 3'd0, 1, 0, 0,  1, 1, 1, 1, 1, 0);
    run_vecs("pre_rst");
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", zero_e);
    do_reset();
    v(0, 0,     0, 0,     3'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    v(1, 'h100, 0, 0,     3'd0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    run_vecs("post_rst");

    // Randomised phase against the behavioural model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      vec_t t;
      t.lk_v = 1'($urandom_range(0, 1)); t.lk_pc = rand_pc();
      t.rs_v = 1'($urandom_range(0, 1)); t.rs_pc = rand_pc();
      t.f3 = 3'($urandom_range(0, 7));   t.z = 1'($urandom_range(0, 1));
      t.lt = 1'($urandom_range(0, 1));   t.pred = 1'($urandom_range(0, 1));
      model_step(t);
      apply(t, $sformatf("rnd%0d", i));
    end

`ifdef ARVI_BHT_STATS_EN
    do_reset();
    for (int i = 0; i < 7; i++)
      v(0, 0, 1, 'h10, 3'd0, 1, 0, 1,  0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      v(0, 0, 1, 'h10, 3'd0, 1, 0, 0,  0, 0, 1, 1, 1, 0);
    v(0, 0,   1, 'h10, 3'd2, 1, 0, 0,  0, 0, 1, 0, 0, 1);
    run_vecs("stat");
    check("stat_branches", stat_branches, 32'd10);
    check("stat_mispredicts", stat_mispredicts, 32'd3);
    rst_n = 1'b0;
    #1;
    check("stat_branches_rst", stat_branches, 32'd0);
    check("stat_mispredicts_rst", stat_mispredicts, 32'd0);
    do_reset();
`endif

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
